// File: rtl/camera_ctrl_pkg.sv
// Shared types and constants for the camera configuration sequencer and its SCCB transmitter.
// Holds the state enums, the table-word codes and the last table index.
package camera_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    DECODE,
    START,
    SHIFT,
    STOP,
    DELAY,
    FINISH
  } seq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_SHIFT,
    TX_STOP
  } tx_phase_t;

  localparam logic [15:0] END_WORD   = 16'hFFFF;
  localparam logic [7:0]  DELAY_REG  = 8'hFE;
  localparam logic [5:0]  LAST_INDEX = 6'd63;

  function automatic logic is_delay_word(input logic [15:0] w);
    return w[15:8] == DELAY_REG;
  endfunction

endpackage

// File: rtl/camera_config_sequencer_if.sv
// Config-table read port and SCCB pins of the camera configuration sequencer.
// The master side drives the table address/strobe and the SCCB lines; the slave side returns table data.
interface camera_config_sequencer_if;

  logic [5:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [1:0]  ram_byteenable;
  logic [15:0] ram_readdata;
  logic        sio_c;
  logic        sio_d;
  logic        sio_d_oe;

  modport master (
    output ram_address, ram_chipselect, ram_write, ram_byteenable,
    input  ram_readdata,
    output sio_c, sio_d, sio_d_oe
  );

  modport slave (
    input  ram_address, ram_chipselect, ram_write, ram_byteenable,
    output ram_readdata,
    input  sio_c, sio_d, sio_d_oe
  );

endinterface

// File: rtl/camera_sccb_tx.sv
// SCCB 3-phase write engine: START, 27 shifted bits (byte + released 9th bit, x3), STOP.
// One write takes (2+108+2)*CLK_DIV clk; go is accepted only while ready, no ACK is checked.
module camera_sccb_tx
  import camera_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [23:0] data,
  output logic        ready,
  output tx_phase_t   phase,
  output logic        sio_c,
  output logic        sio_d,
  output logic        sio_d_oe
);

  localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  tx_phase_t   phase_q, phase_d;
  logic [QW-1:0] qcnt;
  logic [1:0]  q;
  logic [3:0]  bit_pos;
  logic [1:0]  byte_idx;
  logic [26:0] shreg;
  logic        tick;
  logic        phase_end;
  logic        last_bit;

  assign tick      = (qcnt == Q_LAST);
  assign phase_end = tick && ((phase_q == TX_SHIFT) ? (q == 2'd3) : (q == 2'd1));
  assign last_bit  = (bit_pos == 4'd8) && (byte_idx == 2'd2);
  assign ready     = (phase_q == TX_IDLE);
  assign phase     = phase_q;

  // START and STOP are two quarters each; a data bit is four quarters with SIO_C high in the middle two
  always_comb begin
    phase_d  = phase_q;
    sio_c    = 1'b1;
    sio_d    = 1'b1;
    sio_d_oe = 1'b1;
    case (phase_q)
      TX_IDLE: begin
        if (go) phase_d = TX_START;
      end
      TX_START: begin
        sio_c = (q == 2'd0);
        sio_d = 1'b0;
        if (phase_end) phase_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        sio_c = (q == 2'd1) || (q == 2'd2);
        if (bit_pos == 4'd8) sio_d_oe = 1'b0;
        else                 sio_d    = shreg[26];
        if (phase_end && last_bit) phase_d = TX_STOP;
      end
      TX_STOP: begin
        sio_c = (q == 2'd1);
        sio_d = 1'b0;
        if (phase_end) phase_d = TX_IDLE;
      end
      default: phase_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= TX_IDLE;
      qcnt     <= '0;
      q        <= '0;
      bit_pos  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      phase_q <= phase_d;
      if (phase_q == TX_IDLE) begin
        qcnt     <= '0;
        q        <= '0;
        bit_pos  <= '0;
        byte_idx <= '0;
        if (go) shreg <= {data[23:16], 1'b1, data[15:8], 1'b1, data[7:0], 1'b1};
      end else begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        if (phase_end)  q <= '0;
        else if (tick)  q <= q + 2'd1;
        if ((phase_q == TX_SHIFT) && phase_end) begin
          shreg <= {shreg[25:0], 1'b0};
          if (bit_pos == 4'd8) begin
            bit_pos  <= '0;
            byte_idx <= byte_idx + 2'd1;
          end else begin
            bit_pos <= bit_pos + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/camera_config_sequencer.sv
// Walks a 64-word config table, issuing SCCB writes, timed delays, stopping at 16'hFFFF or word 63.
// Table word captured 2 clk after FETCH; start is ignored while busy; done pulses one clk at the end.
module camera_config_sequencer
  import camera_ctrl_pkg::*;
#(
  parameter int          CLK_DIV    = 250,
  parameter logic [7:0]  DEVICE_ID  = 8'h42,
  parameter int          DELAY_UNIT = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  camera_config_sequencer_if.master bus
);

  seq_state_t  state_q, state_d;
  logic [5:0]  index;
  logic [15:0] word_q;
  logic [23:0] dcnt;
  logic        is_end;
  logic        is_delay;
  logic        last;
  logic        advance;
  logic        tx_go;
  logic        tx_ready;
  tx_phase_t   tx_phase;

  assign is_end   = (word_q == END_WORD);
  assign is_delay = is_delay_word(word_q);
  assign last     = (index == LAST_INDEX);

  assign busy               = (state_q != IDLE);
  assign done               = (state_q == FINISH);
  assign bus.ram_address    = index;
  assign bus.ram_chipselect = (state_q == FETCH);
  assign bus.ram_write      = 1'b0;
  assign bus.ram_byteenable = 2'b11;

  // advance = current word finished; the table ends after word 63 even without a terminator
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    tx_go   = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = WAIT_RD;
      WAIT_RD: state_d = DECODE;
      DECODE: begin
        if (is_end) begin
          state_d = FINISH;
        end else if (is_delay) begin
          if (word_q[7:0] == 8'd0) advance = 1'b1;
          else                     state_d = DELAY;
        end else begin
          tx_go   = 1'b1;
          state_d = START;
        end
      end
      START:   if (tx_phase == TX_SHIFT) state_d = SHIFT;
      SHIFT:   if (tx_phase == TX_STOP)  state_d = STOP;
      STOP:    if (tx_ready) advance = 1'b1;
      DELAY:   if (dcnt <= 24'd1) advance = 1'b1;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) state_d = last ? FINISH : FETCH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      index   <= '0;
      word_q  <= '0;
      dcnt    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) index <= '0;
      else if (advance && !last)      index <= index + 6'd1;
      if (state_q == WAIT_RD) word_q <= bus.ram_readdata;
      if ((state_q == DECODE) && is_delay)
        dcnt <= 24'(word_q[7:0]) * 24'(DELAY_UNIT);
      else if ((state_q == DELAY) && (dcnt != 24'd0))
        dcnt <= dcnt - 24'd1;
    end
  end

  camera_sccb_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (tx_go),
    .data     ({DEVICE_ID, word_q}),
    .ready    (tx_ready),
    .phase    (tx_phase),
    .sio_c    (bus.sio_c),
    .sio_d    (bus.sio_d),
    .sio_d_oe (bus.sio_d_oe)
  );

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Directed bench for camera_config_sequencer: table RAM model plus an SCCB bus monitor.
// Each task programs a table, runs it, and checks bytes, fetch order, timing and pulses.
module tb_camera_config_sequencer;

  localparam int CLK_DIV    = 2;
  localparam int DELAY_UNIT = 10;
  localparam logic [14:0] RST_VEC = {1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11};

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic start   = 1'b0;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;

  camera_config_sequencer_if bus ();

  camera_config_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .DEVICE_ID  (8'h42),
    .DELAY_UNIT (DELAY_UNIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  logic [15:0] rd_q;
  always @(posedge clk) if (bus.ram_chipselect) rd_q <= mem[bus.ram_address];
  assign bus.ram_readdata = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor: decodes SCCB bytes, counts edges/conditions, logs fetches
  bit         mon_clr = 1'b0;
  int         mon_bits, mon_starts, mon_stops, mon_edges, mon_err, mon_done;
  bit         mon_in;
  logic [7:0] mon_sh;
  logic       prev_c = 1'b1;
  logic       prev_d = 1'b1;
  logic [7:0] mon_bytes [$];
  int         fetch_addr [$];
  int         fetch_cyc [$];

  always @(negedge clk) begin
    if (!reset_n || mon_clr) begin
      mon_bits = 0; mon_starts = 0; mon_stops = 0; mon_edges = 0; mon_err = 0; mon_done = 0;
      mon_in = 1'b0; mon_sh = '0; prev_c = 1'b1; prev_d = 1'b1;
      mon_bytes.delete(); fetch_addr.delete(); fetch_cyc.delete();
    end else begin
      if (bus.ram_chipselect) begin
        fetch_addr.push_back(int'(bus.ram_address));
        fetch_cyc.push_back(cyc);
      end
      if (done) mon_done++;
      if (prev_c && bus.sio_c && (prev_d != bus.sio_d)) begin
        if (!bus.sio_d) begin
          if (mon_in) mon_err++;
          mon_in = 1'b1; mon_bits = 0; mon_starts++;
        end else begin
          if (!mon_in || mon_bits != 27) mon_err++;
          mon_in = 1'b0; mon_stops++;
        end
      end
      if (!prev_c && bus.sio_c) begin
        mon_edges++;
        if (mon_in && mon_bits < 27) begin
          if (mon_bits % 9 == 8) begin
            if (bus.sio_d_oe) mon_err++;
            mon_bytes.push_back(mon_sh);
          end else begin
            if (!bus.sio_d_oe) mon_err++;
            mon_sh = {mon_sh[6:0], bus.sio_d};
          end
          mon_bits++;
        end else if (!mon_in) begin
          mon_err++;
        end
      end
      prev_c = bus.sio_c;
      prev_d = bus.sio_d;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic busy_at);
    seen    = 1'b0;
    busy_at = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        busy_at = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] rv;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    rv = {busy, done, bus.ram_chipselect, bus.ram_address, bus.sio_c, bus.sio_d,
          bus.sio_d_oe, bus.ram_write, bus.ram_byteenable};
    n_checks++;
    if (rv !== RST_VEC) begin n_fail++; $display("FAIL reset_outputs: got %h required %h", rv, RST_VEC); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rv = {busy, done, bus.ram_chipselect, bus.ram_address, bus.sio_c, bus.sio_d,
          bus.sio_d_oe, bus.ram_write, bus.ram_byteenable};
    n_checks++;
    if (rv !== RST_VEC) begin n_fail++; $display("FAIL idle_after_reset: got %h required %h", rv, RST_VEC); end
  endtask

  task automatic test_two_writes();
    bit seen; logic busy_at; int bad;
    logic [7:0] exp_b [6];
    exp_b = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h00};
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    clear_mon();
    pulse_start();
    wait_done(3000, seen, busy_at);
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL two_writes_done: seen=%0d required 1", seen); end
    n_checks++;
    if (busy_at !== 1'b1) begin n_fail++; $display("FAIL two_writes_busy_at_done: got %b required 1", busy_at); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL two_writes_busy_fall: got %b required 0", busy); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (mon_done != 1) begin n_fail++; $display("FAIL two_writes_done_count: got %0d required 1", mon_done); end
    bad = 0;
    for (int i = 0; i < 6; i++) if (i < mon_bytes.size() && mon_bytes[i] !== exp_b[i]) bad++;
    n_checks++;
    if (bad != 0 || mon_bytes.size() != 6) begin
      n_fail++; $display("FAIL two_writes_bytes: %0d wrong of %0d bytes, required 0 wrong of 6", bad, mon_bytes.size());
    end
    n_checks++;
    if (mon_starts != 2 || mon_stops != 2) begin
      n_fail++; $display("FAIL two_writes_conditions: starts=%0d stops=%0d required 2/2", mon_starts, mon_stops);
    end
    n_checks++;
    if (mon_edges != 56) begin n_fail++; $display("FAIL two_writes_sioc_edges: got %0d required 56", mon_edges); end
    n_checks++;
    if (mon_err != 0) begin n_fail++; $display("FAIL two_writes_protocol: got %0d errors required 0", mon_err); end
    bad = 0;
    for (int i = 0; i < 3; i++) if (i < fetch_addr.size() && fetch_addr[i] != i) bad++;
    n_checks++;
    if (bad != 0 || fetch_addr.size() != 3) begin
      n_fail++; $display("FAIL two_writes_fetch: %0d wrong of %0d fetches, required 0,1,2", bad, fetch_addr.size());
    end
  endtask

  task automatic test_delay();
    bit seen; logic busy_at;
    mem[0] = 16'hFE05; mem[1] = 16'hFE00; mem[2] = 16'hFFFF;
    clear_mon();
    pulse_start();
    wait_done(500, seen, busy_at);
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL delay_done: seen=%0d required 1", seen); end
    n_checks++;
    if (fetch_addr.size() != 3) begin
      n_fail++; $display("FAIL delay_fetch_count: got %0d required 3", fetch_addr.size());
    end else begin
      n_checks++;
      if (fetch_cyc[1] - fetch_cyc[0] != 53) begin
        n_fail++; $display("FAIL delay_gap_50: got %0d clk required 53", fetch_cyc[1] - fetch_cyc[0]);
      end
      n_checks++;
      if (fetch_cyc[2] - fetch_cyc[1] != 3) begin
        n_fail++; $display("FAIL delay_gap_zero: got %0d clk required 3", fetch_cyc[2] - fetch_cyc[1]);
      end
    end
    n_checks++;
    if (mon_edges != 0 || mon_starts != 0) begin
      n_fail++; $display("FAIL delay_bus_quiet: edges=%0d starts=%0d required 0/0", mon_edges, mon_starts);
    end
  endtask

  task automatic test_terminator();
    int k;
    mem[0] = 16'hFFFF;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      k++;
      if (done) break;
    end
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL terminator_latency: done after %0d clk required 4", k); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (mon_edges != 0 || mon_starts != 0 || bus.sio_c !== 1'b1 || bus.sio_d !== 1'b1) begin
      n_fail++; $display("FAIL terminator_bus_quiet: edges=%0d starts=%0d required 0/0", mon_edges, mon_starts);
    end
    n_checks++;
    if (fetch_addr.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL terminator_fetch: got %0d fetches busy=%b required 1 and 0", fetch_addr.size(), busy);
    end
  endtask

  task automatic test_full_table();
    bit seen; logic busy_at; int bad;
    for (int i = 0; i < 64; i++) mem[i] = {8'(i), 8'(i) ^ 8'hA5};
    clear_mon();
    pulse_start();
    wait_done(20000, seen, busy_at);
    repeat (3) @(negedge clk);
    n_checks++;
    if (seen !== 1'b1 || mon_done != 1) begin
      n_fail++; $display("FAIL full_done: seen=%0d pulses=%0d required 1/1", seen, mon_done);
    end
    n_checks++;
    if (mon_stops != 64) begin n_fail++; $display("FAIL full_writes: got %0d required 64", mon_stops); end
    bad = 0;
    for (int i = 0; i < 64; i++) if (i < fetch_addr.size() && fetch_addr[i] != i) bad++;
    n_checks++;
    if (bad != 0 || fetch_addr.size() != 64) begin
      n_fail++; $display("FAIL full_fetch: %0d wrong of %0d fetches, required 0..63", bad, fetch_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (3 * i + 2 < mon_bytes.size()) begin
        if (mon_bytes[3 * i] !== 8'h42)                 bad++;
        if (mon_bytes[3 * i + 1] !== 8'(i))             bad++;
        if (mon_bytes[3 * i + 2] !== (8'(i) ^ 8'hA5))   bad++;
      end
    end
    n_checks++;
    if (bad != 0 || mon_bytes.size() != 192) begin
      n_fail++; $display("FAIL full_bytes: %0d wrong of %0d bytes, required 0 wrong of 192", bad, mon_bytes.size());
    end
    n_checks++;
    if (mon_err != 0) begin n_fail++; $display("FAIL full_protocol: got %0d errors required 0", mon_err); end
  endtask

  task automatic test_reset_mid();
    bit seen; bit hit; logic busy_at; int bad;
    logic [14:0] rv;
    logic [7:0] exp_b [6];
    exp_b = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h00};
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    clear_mon();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mon_stops == 1 && mon_bits == 11) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (hit !== 1'b1 || busy !== 1'b1 || bus.sio_c !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_reach_bit10: hit=%0d busy=%b sio_c=%b required 1/1/1", hit, busy, bus.sio_c);
    end
    #1 reset_n = 1'b0;
    #1;
    rv = {busy, done, bus.ram_chipselect, bus.ram_address, bus.sio_c, bus.sio_d,
          bus.sio_d_oe, bus.ram_write, bus.ram_byteenable};
    n_checks++;
    if (rv !== RST_VEC) begin n_fail++; $display("FAIL reset_mid_outputs: got %h required %h", rv, RST_VEC); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(3000, seen, busy_at);
    repeat (2) @(negedge clk);
    n_checks++;
    if (fetch_addr.size() == 0 || fetch_addr[0] != 0) begin
      n_fail++; $display("FAIL reset_mid_restart_addr: %0d fetches first=%0d required word 0",
                         fetch_addr.size(), (fetch_addr.size() == 0) ? -1 : fetch_addr[0]);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) if (i < mon_bytes.size() && mon_bytes[i] !== exp_b[i]) bad++;
    n_checks++;
    if (seen !== 1'b1 || bad != 0 || mon_bytes.size() != 6) begin
      n_fail++; $display("FAIL reset_mid_rerun: done=%0d %0d wrong of %0d bytes, required done and 6 exact",
                         seen, bad, mon_bytes.size());
    end
  endtask

  task automatic test_start_while_busy();
    bit seen; logic busy_at; int bad;
    logic [7:0] exp_b [6];
    exp_b = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h00};
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    clear_mon();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      repeat (37) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(3000, seen, busy_at);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 3; i++) if (i < fetch_addr.size() && fetch_addr[i] != i) bad++;
    n_checks++;
    if (bad != 0 || fetch_addr.size() != 3) begin
      n_fail++; $display("FAIL busy_start_fetch: %0d wrong of %0d fetches, required 0,1,2", bad, fetch_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 6; i++) if (i < mon_bytes.size() && mon_bytes[i] !== exp_b[i]) bad++;
    n_checks++;
    if (bad != 0 || mon_bytes.size() != 6) begin
      n_fail++; $display("FAIL busy_start_bytes: %0d wrong of %0d bytes, required 0 wrong of 6", bad, mon_bytes.size());
    end
    n_checks++;
    if (seen !== 1'b1 || mon_done != 1) begin
      n_fail++; $display("FAIL busy_start_done: seen=%0d pulses=%0d required 1/1", seen, mon_done);
    end
    n_checks++;
    if (mon_err != 0) begin n_fail++; $display("FAIL busy_start_sda_stable: got %0d errors required 0", mon_err); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
    test_reset();
    test_two_writes();
    test_delay();
    test_terminator();
    test_full_table();
    test_reset_mid();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded 2 ms");
    $fatal(1);
  end

endmodule
